// File: rtl/stream_hash_pkg.sv
// Shared types, constants and round helpers for the stream hash sink.
package stream_hash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  typedef logic [1:0] round_t;

  localparam logic CH_DATA = 1'b0;
  localparam logic CH_MGMT = 1'b1;

  localparam int HASH_W = 16;
  localparam int ROT    = 3;
  localparam int ROUNDS = 4;

  localparam round_t LAST_ROUND = round_t'(ROUNDS - 1);

  function automatic logic [15:0] rotl16(input logic [15:0] v);
    return (v << ROT) | (v >> (HASH_W - ROT));
  endfunction

  function automatic logic [15:0] hash_round(input logic [15:0] h, input logic [3:0] nib);
    return rotl16(h) ^ {12'h000, nib};
  endfunction

  // Nibbles are consumed most-significant first.
  function automatic logic [3:0] pick_nibble(input logic [15:0] w, input round_t r);
    logic [3:0] nib;
    case (r)
      2'd0:    nib = w[15:12];
      2'd1:    nib = w[11:8];
      2'd2:    nib = w[7:4];
      default: nib = w[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/stream_hash_out_reg.sv
// One-deep Avalon-ST source register holding the most recent digest.
module stream_hash_out_reg
  import stream_hash_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              free_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;

  // Free when empty or when the held word leaves on this edge.
  assign free_o = ~valid_q | ready_i;

  // Next-state: load wins over drain so a simultaneous take/refill stays valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/stream_hash_sink.sv
// Avalon-ST sink folding channel-0 words into a 16-bit rotate/xor hash;
// channel-1 beats arm the block and reseed it. Only DATA_W = 16 is supported.
module stream_hash_sink
  import stream_hash_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter logic [15:0] SEED   = 16'h0000,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_channel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e            state_q;
  state_e            state_d;
  logic [15:0]       hash_q;
  logic [15:0]       hash_d;
  logic [15:0]       word_q;
  logic [15:0]       word_d;
  round_t            round_q;
  round_t            round_d;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  word_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic [CNT_W-1:0]  drop_cnt_d;
  logic              in_ready_q;

  logic              accept_s;
  logic              out_free_s;
  logic              emit_load_s;

  assign accept_s = in_valid & in_ready_q;

  // FSM, hash datapath and counters next-state.
  always_comb begin
    state_d     = state_q;
    hash_d      = hash_q;
    word_d      = word_q;
    round_d     = round_q;
    word_cnt_d  = word_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    emit_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (in_channel == CH_MGMT)) begin
          hash_d     = SEED;
          word_cnt_d = CNT_ZERO;
          state_d    = ST_ARMED;
        end else if (accept_s) begin
          drop_cnt_d = (drop_cnt_q == CNT_MAX) ? drop_cnt_q : drop_cnt_q + CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // in_data is only sampled on data beats, so X on management beats stays out.
        if (accept_s && (in_channel == CH_MGMT)) begin
          hash_d     = SEED;
          word_cnt_d = CNT_ZERO;
        end else if (accept_s) begin
          word_d  = in_data[15:0];
          round_d = 2'd0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_BUSY: begin
        hash_d  = hash_round(hash_q, pick_nibble(word_q, round_q));
        round_d = round_q + 2'd1;
        if (round_q == LAST_ROUND) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_EMIT: begin
        if (out_free_s) begin
          emit_load_s = 1'b1;
          word_cnt_d  = (word_cnt_q == CNT_MAX) ? word_cnt_q : word_cnt_q + CNT_ONE;
          state_d     = ST_ARMED;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hash_q     <= SEED;
      word_q     <= 16'h0000;
      round_q    <= 2'd0;
      word_cnt_q <= CNT_ZERO;
      drop_cnt_q <= CNT_ZERO;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hash_q     <= hash_d;
      word_q     <= word_d;
      round_q    <= round_d;
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      in_ready_q <= (state_d == ST_IDLE) || (state_d == ST_ARMED);
    end
  end

  stream_hash_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (emit_load_s),
    .data_i  (hash_q),
    .ready_i (out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .free_o  (out_free_s)
  );

  assign in_ready   = in_ready_q;
  assign word_count = word_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_stream_hash_sink.sv
// Directed bench for stream_hash_sink with hand-computed digests.
module tb_stream_hash_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_channel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_hash_sink #(
    .DATA_W (16),
    .SEED   (16'h0000),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_channel (in_channel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count),
    .drop_count (drop_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one beat for exactly one edge.
  task automatic send(input logic ch, input logic [15:0] d);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check_eq("send_ready_timeout", 32'(in_ready), 32'd1);
    in_channel = ch;
    in_data    = d;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_channel = 1'b0;
    in_data    = 16'h0000;
  endtask

  // Called just after an accepting edge T with no output pending.
  task automatic expect_word(input string tag, input logic [15:0] exp, input logic [15:0] exp_wc);
    for (int k = 0; k < 5; k++) begin
      check_eq({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      check_eq({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
      step();
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
    check_eq({tag, "_wc"}, 32'(word_count), 32'(exp_wc));
    check_eq({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    in_data    = 16'h0000;
    in_channel = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    reset      = 1'b0;
    pulse_reset();

    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);

    // Data before arming is dropped.
    send(1'b0, 16'h1234);
    check_eq("drop_ready", 32'(in_ready), 32'd1);
    check_eq("drop_count1", 32'(drop_count), 32'd1);
    repeat (6) step();
    check_eq("drop_no_out", 32'(out_valid), 32'd0);
    check_eq("drop_still_ready", 32'(in_ready), 32'd1);

    // Arm with X data, then hash 0x4949.
    send(1'b1, 16'hxxxx);
    check_eq("arm_wc", 32'(word_count), 32'd0);
    send(1'b0, 16'h4949);
    expect_word("w4949", 16'h0A69, 16'd1);

    // Reseed, then two words chained through the hash.
    send(1'b1, 16'h0000);
    send(1'b0, 16'h0001);
    expect_word("w0001", 16'h0001, 16'd1);
    send(1'b0, 16'h0000);
    expect_word("w0000", 16'h1000, 16'd2);

    // Backpressure: first digest held, second word stalls in EMIT.
    send(1'b1, 16'h0000);
    out_ready = 1'b0;
    send(1'b0, 16'h4949);
    expect_word("bp_a", 16'h0A69, 16'd1);
    send(1'b0, 16'h0000);
    repeat (7) step();
    check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_data", 32'(out_data), 32'h0A69);
    check_eq("bp_hold_wc", 32'(word_count), 32'd1);
    step();
    check_eq("bp_stable_data", 32'(out_data), 32'h0A69);
    out_ready = 1'b1;
    step();
    check_eq("bp_b_valid", 32'(out_valid), 32'd1);
    check_eq("bp_b_data", 32'(out_data), 32'h90A6);
    check_eq("bp_b_wc", 32'(word_count), 32'd2);
    check_eq("bp_b_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Management beat between data words; pending output survives the reseed.
    send(1'b1, 16'hxxxx);
    out_ready = 1'b0;
    send(1'b0, 16'h4949);
    expect_word("mid_a", 16'h0A69, 16'd1);
    send(1'b1, 16'hxxxx);
    check_eq("mid_pend_valid", 32'(out_valid), 32'd1);
    check_eq("mid_pend_data", 32'(out_data), 32'h0A69);
    check_eq("mid_pend_wc", 32'(word_count), 32'd0);
    out_ready = 1'b1;
    send(1'b0, 16'h4949);
    expect_word("mid_b", 16'h0A69, 16'd1);

    // Reset in BUSY aborts the word and disarms the block.
    send(1'b1, 16'h0000);
    send(1'b0, 16'h4949);
    step();
    check_eq("abort_busy", 32'(in_ready), 32'd0);
    pulse_reset();
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_drop", 32'(drop_count), 32'd0);
    check_eq("abort_wc", 32'(word_count), 32'd0);
    check_eq("abort_ready", 32'(in_ready), 32'd1);
    send(1'b0, 16'h1234);
    check_eq("abort_drop1", 32'(drop_count), 32'd1);
    repeat (6) step();
    check_eq("abort_no_out", 32'(out_valid), 32'd0);
    send(1'b1, 16'h0000);
    send(1'b0, 16'h4949);
    expect_word("recover", 16'h0A69, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
